// File: rtl/md_unit.sv
`timescale 1ns/1ps
// Iterative multiply/divide unit owning the architectural HI/LO registers.
// One radix-2 shift-add or restoring-divide step per cycle; sign fix-up in a final FIX cycle.
module md_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       md_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [1:0]       dbg_state_o
);

  localparam int W2 = 2 * WIDTH;

  // Handshake: start is sampled only in IDLE; busy/done are registered, no path from start.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [4:0]       cnt_q, cnt_d;
  logic [W2-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] araw_q, araw_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             is_div_q, is_div_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic             div0_q, div0_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             signed_op;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   rem_sh;
  logic             rem_ge;
  logic [WIDTH-1:0] rem_new;
  logic [W2-1:0]    prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  assign signed_op = ~md_op[0];
  assign abs_a     = (signed_op && a[WIDTH-1]) ? (~a + 1'b1) : a;
  assign abs_b     = (signed_op && b[WIDTH-1]) ? (~b + 1'b1) : b;

  // Multiply: add multiplicand into the upper half, then shift the whole accumulator right.
  assign mul_sum = {1'b0, acc_q[W2-1:WIDTH]} + {1'b0, (opb_q[0] ? opa_q : '0)};

  // Divide: partial remainder lives in acc upper half, quotient bits shift into the lower half.
  assign rem_sh  = {acc_q[W2-1:WIDTH], opa_q[WIDTH-1]};
  assign rem_ge  = rem_sh >= {1'b0, opb_q};
  assign rem_new = rem_ge ? (rem_sh[WIDTH-1:0] - opb_q) : rem_sh[WIDTH-1:0];

  assign prod_fix = neg_quo_q ? (~acc_q + 1'b1) : acc_q;
  assign quo_fix  = neg_quo_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
  assign rem_fix  = neg_rem_q ? (~acc_q[W2-1:WIDTH] + 1'b1) : acc_q[W2-1:WIDTH];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    araw_d    = araw_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    is_div_d  = is_div_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (!md_op[2]) begin
            state_d   = S_CALC;
            busy_d    = 1'b1;
            cnt_d     = '0;
            acc_d     = '0;
            opa_d     = abs_a;
            opb_d     = abs_b;
            araw_d    = a;
            is_div_d  = md_op[1];
            neg_quo_d = signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_rem_d = signed_op & a[WIDTH-1];
            div0_d    = (b == '0);
          end else if (md_op == 3'd4) begin
            hi_d = a;
          end else if (md_op == 3'd5) begin
            lo_d = a;
          end
        end
      end
      S_CALC: begin
        cnt_d = cnt_q + 5'd1;
        if (is_div_q) begin
          acc_d = {rem_new, acc_q[WIDTH-2:0], rem_ge};
          opa_d = {opa_q[WIDTH-2:0], 1'b0};
        end else begin
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
          opb_d = {1'b0, opb_q[WIDTH-1:1]};
        end
        if (cnt_q == 5'd31) state_d = S_FIX;
      end
      S_FIX: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        if (!is_div_q) begin
          hi_d = prod_fix[W2-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end else if (div0_q) begin
          // Divide by zero returns the raw dividend, bypassing the sign fix.
          hi_d = araw_q;
          lo_d = '1;
        end else begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      araw_q    <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      is_div_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      araw_q    <= araw_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      is_div_q  <= is_div_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      div0_q    <= div0_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_md_unit.sv
`timescale 1ns/1ps
// Bench for md_unit: directed literal cases plus random traffic against a
// cycle-level model built from plain 64-bit arithmetic.
module tb_md_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  md_op = 3'd0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        busy, done;
  logic [31:0] hi, lo;
  logic [1:0]  dbg_state;

  int checks = 0;
  int failures = 0;

  md_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .md_op(md_op), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Architectural result {hi, lo} of a mul/div op.
  function automatic logic [63:0] ref_md(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy;
    int q, r;
    ref_md = 64'd0;
    case (op)
      3'd0: begin
        sx = $signed(x);
        sy = $signed(y);
        ref_md = sx * sy;
      end
      3'd1: ref_md = {32'd0, x} * {32'd0, y};
      3'd2: begin
        if (y == 32'd0) ref_md = {x, 32'hFFFFFFFF};
        else if (x == 32'h80000000 && y == 32'hFFFFFFFF) ref_md = {32'd0, 32'h80000000};
        else begin
          q = $signed(x) / $signed(y);
          r = $signed(x) % $signed(y);
          ref_md = {r, q};
        end
      end
      3'd3: begin
        if (y == 32'd0) ref_md = {x, 32'hFFFFFFFF};
        else ref_md = {x % y, x / y};
      end
      default: ref_md = 64'd0;
    endcase
  endfunction

  // Model: an accepted mul/div lands 33 edges later; anything else while pending is dropped.
  logic [31:0] m_hi, m_lo, p_hi, p_lo;
  logic        m_busy, m_done;
  int          m_left;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_hi <= 32'd0; m_lo <= 32'd0; p_hi <= 32'd0; p_lo <= 32'd0;
      m_busy <= 1'b0; m_done <= 1'b0; m_left <= 0;
    end else begin
      m_done <= 1'b0;
      if (m_left > 0) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_hi <= p_hi; m_lo <= p_lo; m_done <= 1'b1; m_busy <= 1'b0;
        end
      end else if (start) begin
        if (md_op <= 3'd3) begin
          {p_hi, p_lo} <= ref_md(md_op, a, b);
          m_left <= 33;
          m_busy <= 1'b1;
        end else if (md_op == 3'd4) m_hi <= a;
        else if (md_op == 3'd5) m_lo <= a;
      end
    end
  end

  always @(negedge clk) begin
    chk("cyc_busy", {63'd0, busy}, {63'd0, m_busy});
    chk("cyc_done", {63'd0, done}, {63'd0, m_done});
    chk("cyc_hi", {32'd0, hi}, {32'd0, m_hi});
    chk("cyc_lo", {32'd0, lo}, {32'd0, m_lo});
  end

  task automatic issue(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    start = 1'b1; md_op = op; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int busy_cycles);
    busy_cycles = 0;
    for (int k = 0; k < 40; k++) begin
      if (done) break;
      if (busy) busy_cycles++;
      @(negedge clk);
    end
    chk("done_seen", {63'd0, done}, 64'd1);
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo, input string name);
    int bc;
    issue(op, x, y);
    wait_done(bc);
    chk({name, "_hi"}, {32'd0, hi}, {32'd0, exp_hi});
    chk({name, "_lo"}, {32'd0, lo}, {32'd0, exp_lo});
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: pick = 32'd0;
      1: pick = 32'h80000000;
      2: pick = 32'hFFFFFFFF;
      3: pick = $urandom_range(0, 15);
      default: pick = $urandom;
    endcase
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int bc;
    repeat (2) @(negedge clk);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_hilo", {hi, lo}, 64'd0);
    rst_n = 1'b1;

    issue(3'd0, 32'hFFFFFFFD, 32'd5);
    wait_done(bc);
    chk("mult_busy_len", 64'(bc), 64'd33);
    chk("mult_m3x5_hi", {32'd0, hi}, 64'hFFFFFFFF);
    chk("mult_m3x5_lo", {32'd0, lo}, 64'hFFFFFFF1);
    chk("mult_busy_at_done", {63'd0, busy}, 64'd0);
    @(negedge clk);
    chk("done_one_cycle", {63'd0, done}, 64'd0);

    run_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, "multu_max");
    run_op(3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, "mult_m1m1");
    run_op(3'd2, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, "div_m7_2");
    run_op(3'd3, 32'd7, 32'd2, 32'd1, 32'd3, "divu_7_2");
    run_op(3'd3, 32'd7, 32'd0, 32'd7, 32'hFFFFFFFF, "divu_by0");
    run_op(3'd2, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF, "div_neg_by0");
    run_op(3'd2, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, "div_ovf");

    issue(3'd4, 32'h12345678, 32'd0);
    chk("mthi_hi", {32'd0, hi}, 64'h12345678);
    chk("mthi_busy", {63'd0, busy}, 64'd0);
    issue(3'd1, 32'd3, 32'd4);
    repeat (3) @(negedge clk);
    issue(3'd5, 32'h0000DEAD, 32'd0);
    wait_done(bc);
    chk("mtlo_ign_hi", {32'd0, hi}, 64'd0);
    chk("mtlo_ign_lo", {32'd0, lo}, 64'hC);

    issue(3'd3, 32'd100, 32'd7);
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", {63'd0, busy}, 64'd0);
    chk("arst_done", {63'd0, done}, 64'd0);
    chk("arst_hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(3'd3, 32'd100, 32'd7, 32'd2, 32'd14, "divu_100_7");

    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      start = ($urandom_range(0, 2) == 0);
      md_op = 3'($urandom_range(0, 7));
      a = pick();
      b = pick();
    end
    @(negedge clk);
    start = 1'b0;
    repeat (40) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
